// File: rtl/seq1000_detector.sv
// seq1000_detector
// Moore serial sequence detector. Samples `in` on every rising edge of
// `clock` and raises `out` for exactly one cycle once the bit pattern
// 1,0,0,0 (oldest first) has been received. Overlapping matches restart
// on a fresh 1; a run of zeros never re-triggers the flag.
//
// Interface timing: no handshake. `in` is a plain synchronous level sampled
// every cycle, and `out` is a registered level that is valid for the whole
// cycle following the edge that sampled the final 0.
//
// `dbg_state` mirrors the registered FSM state so that checkers can observe
// the state without reaching into the hierarchy.

module seq1000_detector (
  input  logic       clock,
  input  logic       reset,     // asynchronous, active-low
  input  logic       in,
  output logic       out,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,  // no useful history
    S1   = 3'd1,  // last bit was 1
    S10  = 3'd2,  // seen 1,0
    S100 = 3'd3,  // seen 1,0,0
    DET  = 3'd4   // seen 1,0,0,0
  } state_e;

  state_e state_q, state_d;
  logic   out_q, out_d;

  // Next-state logic; unreachable encodings fall back to IDLE.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = in ? S1 : IDLE;
      S1:      state_d = in ? S1 : S10;
      S10:     state_d = in ? S1 : S100;
      S100:    state_d = in ? S1 : DET;
      DET:     state_d = in ? S1 : IDLE;
      default: state_d = IDLE;
    endcase
    // Registered alongside the state so the flag is glitch-free and
    // has no combinational path from `in`.
    out_d = (state_d == DET);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign out       = out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq1000_detector.sv
// Testbench for seq1000_detector: directed scenarios with hand-written
// expected pulse tables, plus a long random bit stream checked against a
// history-based reference (flag = the last four bits since reset are 1000).

module tb_seq1000_detector;

  logic       clock;
  logic       reset;
  logic       in_bit;
  logic       out_bit;
  logic [2:0] dbg_state;

  int checks;
  int errors;

  // Reference history: every bit sampled since the last reset.
  logic hist_q[$];

  seq1000_detector dut (
    .clock     (clock),
    .reset     (reset),
    .in        (in_bit),
    .out       (out_bit),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_reset();
    @(negedge clock);
    reset  = 1'b0;
    in_bit = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    hist_q.delete();
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_out();
    int n;
    n = hist_q.size();
    if (n < 4) return 1'b0;
    return (hist_q[n-4] == 1'b1) && (hist_q[n-3] == 1'b0) &&
           (hist_q[n-2] == 1'b0) && (hist_q[n-1] == 1'b0);
  endfunction

  // ---------------- driver ----------------
  // Drives one bit, lets one rising edge sample it, and returns the
  // reference expectation for `out` 1 time unit after that edge.
  task automatic drive_bit(input logic b, output logic exp);
    in_bit = b;
    @(posedge clock);
    #1;
    hist_q.push_back(b);
    exp = model_out();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic e;
    @(negedge clock);
    reset  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_bit = i[0];
      @(negedge clock);
      checks++;
      if (out_bit !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d out=%b expected=0", i, out_bit);
      end
    end
    reset  = 1'b1;
    hist_q.delete();
    for (int i = 0; i < 2; i++) begin
      drive_bit(1'b0, e);
      checks++;
      if (out_bit !== 1'b0) begin
        errors++;
        $display("FAIL reset_release edge=%0d out=%b expected=0", i + 1, out_bit);
      end
    end
  endtask

  task automatic run_table(input string name, input logic pat[], input logic want[]);
    logic e;
    do_reset();
    for (int i = 0; i < pat.size(); i++) begin
      drive_bit(pat[i], e);
      checks++;
      if (out_bit !== want[i]) begin
        errors++;
        $display("FAIL %s edge=%0d out=%b expected=%b", name, i + 1, out_bit, want[i]);
      end
    end
  endtask

  task automatic test_basic_detect();
    run_table("basic_detect", '{1,0,0,0,0}, '{0,0,0,1,0});
  endtask

  task automatic test_broken_pattern();
    run_table("broken_pattern", '{1,0,1,0,0,0}, '{0,0,0,0,0,1});
  endtask

  task automatic test_back_to_back();
    run_table("back_to_back", '{1,0,0,0,1,0,0,0}, '{0,0,0,1,0,0,0,1});
  endtask

  task automatic test_repeat_ones();
    run_table("repeat_ones", '{1,1,1,0,0,0,0}, '{0,0,0,0,0,1,0});
  endtask

  task automatic test_long_zeros();
    run_table("long_zeros", '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0});
    run_table("zeros_after_det", '{1,0,0,0,0,0,0,0,0,0}, '{0,0,0,1,0,0,0,0,0,0});
  endtask

  task automatic test_async_reset();
    logic e;
    // Pulse in progress must drop as soon as reset asserts, between edges.
    do_reset();
    drive_bit(1'b1, e);
    drive_bit(1'b0, e);
    drive_bit(1'b0, e);
    drive_bit(1'b0, e);
    checks++;
    if (out_bit !== 1'b1) begin
      errors++;
      $display("FAIL async_pre_pulse out=%b expected=1", out_bit);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_bit !== 1'b0) begin
      errors++;
      $display("FAIL async_pulse_kill out=%b expected=0", out_bit);
    end
    @(negedge clock);
    reset = 1'b1;
    hist_q.delete();

    // Partial history 1,0,0 is discarded by a mid-pattern reset.
    drive_bit(1'b1, e);
    drive_bit(1'b0, e);
    drive_bit(1'b0, e);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_bit !== 1'b0) begin
      errors++;
      $display("FAIL async_mid_pattern out=%b expected=0", out_bit);
    end
    @(negedge clock);
    reset = 1'b1;
    hist_q.delete();
    for (int i = 0; i < 3; i++) begin
      drive_bit(1'b0, e);
      checks++;
      if (out_bit !== 1'b0) begin
        errors++;
        $display("FAIL async_history_cleared edge=%0d out=%b expected=0", i + 1, out_bit);
      end
    end
  endtask

  task automatic test_random();
    logic b;
    logic e;
    int   pulses;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      b = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
      drive_bit(b, e);
      if (e) pulses++;
      checks++;
      if (out_bit !== e) begin
        errors++;
        $display("FAIL random edge=%0d in=%b out=%b expected=%b", i + 1, b, out_bit, e);
      end
    end
    checks++;
    if (pulses == 0) begin
      errors++;
      $display("FAIL random_coverage pulses=%0d expected>0", pulses);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    in_bit = 1'b0;
    #12;
    checks++;
    if (out_bit !== 1'b0) begin
      errors++;
      $display("FAIL power_on_reset out=%b expected=0", out_bit);
    end
    reset = 1'b1;

    test_reset();
    test_basic_detect();
    test_broken_pattern();
    test_back_to_back();
    test_repeat_ones();
    test_long_zeros();
    test_async_reset();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
